// File: rtl/axi_master_ctrl.sv
// axi_master_ctrl: single-outstanding AXI4 master. Converts one local command
// into a complete AXI write (AW/W/B) or read (AR/R) burst, counts beats,
// checks RLAST framing, reports the burst response and aborts a transaction
// that sees no handshake for TIMEOUT cycles.
//
// Ports
//   aclk, areset_n          clock (rising edge), async active-low reset
//   cmd_*                   local command handshake and burst fields
//   wr_data_*               local write-data stream (passed through to W)
//   rd_data_*, rd_last      local read-data stream (passed through from R)
//   done, done_*            one-cycle completion pulse plus held status
//   aw*/w*/b*/ar*/r*        AXI4 master channels
module axi_master_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              aclk,
  input  logic              areset_n,
  // local command interface
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  // local write data
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  input  logic [DATA_W-1:0] wr_data,
  // local read data
  output logic              rd_data_valid,
  input  logic              rd_data_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  // completion status
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              done_timeout,
  output logic              done_proto_err,
  // AXI write address
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI read address
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [1:0]          resp_acc_q, resp_acc_d;
  logic                proto_err_q, proto_err_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                done_q, done_d;
  logic [1:0]          done_resp_q, done_resp_d;
  logic                done_timeout_q, done_timeout_d;
  logic                done_proto_err_q, done_proto_err_d;

  logic                last_beat;
  logic [1:0]          resp_max;
  logic                beat_err;
  logic                hs;

  // Beat counter reaching the latched length marks the final beat.
  assign last_beat = (beat_cnt_q == len_q);
  // Worst-case response so far, including the current R beat.
  assign resp_max  = (rresp > resp_acc_q) ? rresp : resp_acc_q;
  // RLAST must be high exactly on the final beat.
  assign beat_err  = (rlast != last_beat);

  // Next-state and datapath update.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_d            = len_q;
    size_d           = size_q;
    burst_d          = burst_q;
    beat_cnt_d       = beat_cnt_q;
    resp_acc_d       = resp_acc_q;
    proto_err_d      = proto_err_q;
    timer_d          = timer_q;
    done_d           = 1'b0;
    done_resp_d      = done_resp_q;
    done_timeout_d   = done_timeout_q;
    done_proto_err_d = done_proto_err_q;
    hs               = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          len_d       = cmd_len;
          size_d      = cmd_size;
          burst_d     = cmd_burst;
          beat_cnt_d  = 8'd0;
          resp_acc_d  = 2'b00;
          proto_err_d = 1'b0;
          timer_d     = '0;
          state_d     = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        if (awready) begin
          hs      = 1'b1;
          state_d = S_W;
        end
      end
      S_W: begin
        if (wr_data_valid && wready) begin
          hs         = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) begin
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (bvalid) begin
          hs               = 1'b1;
          state_d          = S_IDLE;
          done_d           = 1'b1;
          done_resp_d      = bresp;
          done_timeout_d   = 1'b0;
          done_proto_err_d = 1'b0;
        end
      end
      S_AR: begin
        if (arready) begin
          hs      = 1'b1;
          state_d = S_R;
        end
      end
      S_R: begin
        if (rvalid && rd_data_ready) begin
          hs          = 1'b1;
          beat_cnt_d  = beat_cnt_q + 8'd1;
          resp_acc_d  = resp_max;
          proto_err_d = proto_err_q | beat_err;
          // An early RLAST is only flagged; the burst ends on beat count.
          if (last_beat) begin
            state_d          = S_IDLE;
            done_d           = 1'b1;
            done_resp_d      = resp_max;
            done_timeout_d   = 1'b0;
            done_proto_err_d = proto_err_q | beat_err;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Inactivity watchdog: any channel handshake restarts the count.
    if (state_q != S_IDLE) begin
      if (hs) begin
        timer_d = '0;
      end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
        state_d          = S_IDLE;
        done_d           = 1'b1;
        done_resp_d      = RESP_SLVERR;
        done_timeout_d   = 1'b1;
        done_proto_err_d = proto_err_q;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  // State and status registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      len_q            <= 8'd0;
      size_q           <= 3'd0;
      burst_q          <= 2'd0;
      beat_cnt_q       <= 8'd0;
      resp_acc_q       <= 2'd0;
      proto_err_q      <= 1'b0;
      timer_q          <= '0;
      done_q           <= 1'b0;
      done_resp_q      <= 2'd0;
      done_timeout_q   <= 1'b0;
      done_proto_err_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      size_q           <= size_d;
      burst_q          <= burst_d;
      beat_cnt_q       <= beat_cnt_d;
      resp_acc_q       <= resp_acc_d;
      proto_err_q      <= proto_err_d;
      timer_q          <= timer_d;
      done_q           <= done_d;
      done_resp_q      <= done_resp_d;
      done_timeout_q   <= done_timeout_d;
      done_proto_err_q <= done_proto_err_d;
    end
  end

  // Command ready is held low while reset is asserted.
  assign cmd_ready      = areset_n && (state_q == S_IDLE);

  // Address channels present the latched command fields.
  assign awaddr         = addr_q;
  assign awlen          = len_q;
  assign awsize         = size_q;
  assign awburst        = burst_q;
  assign awvalid        = (state_q == S_AW);
  assign araddr         = addr_q;
  assign arlen          = len_q;
  assign arsize         = size_q;
  assign arburst        = burst_q;
  assign arvalid        = (state_q == S_AR);

  // Write data path: pass-through gated by the W state.
  assign wvalid         = (state_q == S_W) && wr_data_valid;
  assign wr_data_ready  = (state_q == S_W) && wready;
  assign wdata          = (state_q == S_W) ? wr_data : '0;
  assign wlast          = (state_q == S_W) && last_beat;
  assign bready         = (state_q == S_B);

  // Read data path: pass-through gated by the R state.
  assign rready         = (state_q == S_R) && rd_data_ready;
  assign rd_data_valid  = (state_q == S_R) && rvalid;
  assign rd_data        = (state_q == S_R) ? rdata : '0;
  assign rd_last        = (state_q == S_R) && rlast;

  assign done           = done_q;
  assign done_resp      = done_resp_q;
  assign done_timeout   = done_timeout_q;
  assign done_proto_err = done_proto_err_q;

endmodule

// File: tb/tb_axi_master_ctrl.sv
// tb_axi_master_ctrl: directed bench for axi_master_ctrl with a scoreboard.
// Stimulus pushes expected AW/AR/W/R/done records into queues; one monitor
// process pops and compares whenever the DUT presents a handshake or done.
module tb_axi_master_ctrl;

  localparam int unsigned AW_W = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 16;

  logic            aclk = 1'b0;
  logic            areset_n = 1'b0;
  logic            cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW_W-1:0] cmd_addr = '0;
  logic [7:0]      cmd_len = 8'd0;
  logic [2:0]      cmd_size = 3'd0;
  logic [1:0]      cmd_burst = 2'd0;
  logic            wr_data_valid, wr_data_ready;
  logic [DW-1:0]   wr_data;
  logic            rd_data_valid, rd_data_ready, rd_last;
  logic [DW-1:0]   rd_data;
  logic            done, done_timeout, done_proto_err;
  logic [1:0]      done_resp;
  logic [AW_W-1:0] awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;

  axi_master_ctrl #(.ADDR_W(AW_W), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_timeout(done_timeout),
    .done_proto_err(done_proto_err),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- slave and local-source models ----------------
  logic          aw_rdy_en = 1'b1;
  logic          src_clr = 1'b0;
  logic          rd_tog_en = 1'b0;
  logic          rd_tog = 1'b0;
  logic [DW-1:0] w_mem [0:7];
  logic [DW-1:0] r_mem [0:7];
  logic [1:0]    r_rsp [0:7];
  logic          r_lst [0:7];
  int            w_n = 0, r_n = 0, r_stall_at = -1;
  int            w_idx = 0, r_idx = 0;

  assign awready       = aw_rdy_en;
  assign wready        = 1'b1;
  assign bvalid        = bready;
  assign bresp         = 2'b00;
  assign arready       = 1'b1;
  assign rvalid        = (r_idx < r_n) && (r_idx != r_stall_at);
  assign rdata         = rvalid ? r_mem[r_idx[2:0]] : '0;
  assign rresp         = rvalid ? r_rsp[r_idx[2:0]] : 2'b00;
  assign rlast         = rvalid ? r_lst[r_idx[2:0]] : 1'b0;
  assign wr_data_valid = (w_idx < w_n);
  assign wr_data       = wr_data_valid ? w_mem[w_idx[2:0]] : '0;
  assign rd_data_ready = rd_tog_en ? rd_tog : 1'b1;

  always @(posedge aclk) begin
    rd_tog <= ~rd_tog;
    if (src_clr) begin
      r_idx <= 0;
      w_idx <= 0;
    end else begin
      if (rvalid && rready) r_idx <= r_idx + 1;
      if (wr_data_valid && wr_data_ready) w_idx <= w_idx + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] data; logic last; } beat_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ac_t;
  typedef struct packed { logic [1:0] resp; logic tmo; logic perr; int lat; } done_t;

  beat_t exp_w[$], exp_r[$];
  ac_t   exp_aw[$], exp_ar[$];
  done_t exp_d[$];

  int    n_tests = 0, n_fail = 0;
  int    done_cnt = 0, rd_cnt = 0, cmd_cyc = 0, stim_expired = 0;
  int    req_id = 0, ack_id = 0;
  logic  fin_req = 1'b0, fin_ack = 1'b0;
  string chk_name = "";
  logic [15:0] chk_exp = '0;
  logic [15:0] out_vec;
  logic        fields_nz;

  assign fields_nz = |{awaddr, awlen, awsize, awburst, araddr, arlen, arsize, arburst};
  assign out_vec = {cmd_ready, awvalid, wvalid, wlast, bready, arvalid, rready,
                    wr_data_ready, rd_data_valid, rd_last, done, done_timeout,
                    done_proto_err, done_resp, fields_nz};

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge aclk) begin
    beat_t b;
    ac_t   a;
    done_t d;
    if (req_id != ack_id) begin
      cmp(chk_name, 64'(out_vec), 64'(chk_exp));
      ack_id = req_id;
    end
    if (areset_n) begin
      if (awvalid && awready) begin
        cmp("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
        if (exp_aw.size() != 0) begin
          a = exp_aw.pop_front();
          cmp("awaddr", 64'(awaddr), 64'(a.addr));
          cmp("awlen", 64'(awlen), 64'(a.len));
          cmp("awsize_burst", 64'({awsize, awburst}), 64'({3'd2, 2'b01}));
        end
      end
      if (arvalid && arready) begin
        cmp("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
        if (exp_ar.size() != 0) begin
          a = exp_ar.pop_front();
          cmp("araddr", 64'(araddr), 64'(a.addr));
          cmp("arlen", 64'(arlen), 64'(a.len));
        end
      end
      if (wvalid && wready) begin
        cmp("w_expected", 64'(exp_w.size() != 0), 64'd1);
        if (exp_w.size() != 0) begin
          b = exp_w.pop_front();
          cmp("wdata", 64'(wdata), 64'(b.data));
          cmp("wlast", 64'(wlast), 64'(b.last));
        end
      end
      if (rd_data_valid && rd_data_ready) begin
        rd_cnt++;
        cmp("r_expected", 64'(exp_r.size() != 0), 64'd1);
        if (exp_r.size() != 0) begin
          b = exp_r.pop_front();
          cmp("rd_data", 64'(rd_data), 64'(b.data));
          cmp("rd_last", 64'(rd_last), 64'(b.last));
        end
      end
      if (done) begin
        done_cnt++;
        cmp("done_expected", 64'(exp_d.size() != 0), 64'd1);
        if (exp_d.size() != 0) begin
          d = exp_d.pop_front();
          cmp("done_resp", 64'(done_resp), 64'(d.resp));
          cmp("done_timeout", 64'(done_timeout), 64'(d.tmo));
          cmp("done_proto_err", 64'(done_proto_err), 64'(d.perr));
          if (d.lat >= 0) cmp("done_latency", 64'(cyc - cmd_cyc), 64'(d.lat));
          cmp("done_idle_chan", 64'({awvalid, wvalid, bready, arvalid, rready, cmd_ready}),
              64'(6'b000001));
        end
      end
    end
    if (fin_req && !fin_ack) begin
      cmp("left_w", 64'(exp_w.size()), 64'd0);
      cmp("left_r", 64'(exp_r.size()), 64'd0);
      cmp("left_aw", 64'(exp_aw.size()), 64'd0);
      cmp("left_ar", 64'(exp_ar.size()), 64'd0);
      cmp("left_done", 64'(exp_d.size()), 64'd0);
      cmp("stim_wait_expired", 64'(stim_expired), 64'd0);
      fin_ack = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic check_outs(input string name, input logic [15:0] e);
    chk_name = name;
    chk_exp  = e;
    req_id++;
    tick(1);
  endtask

  task automatic clear_src();
    src_clr = 1'b1;
    tick(1);
    src_clr = 1'b0;
    w_n = 0;
    r_n = 0;
    r_stall_at = -1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int t;
    tick(1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = 3'd2;
    cmd_burst = 2'b01;
    t = 0;
    while (!cmd_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) stim_expired++;
    cmd_cyc = cyc;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_cnt < n && t < 400) begin
      tick(1);
      t++;
    end
    if (t >= 400) stim_expired++;
    tick(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(2);
    check_outs("reset_outputs", 16'h0000);
    areset_n = 1'b1;
    check_outs("after_release", 16'h8000);

    // Write len=3, data A0..A3, always ready: done 7 cycles after cmd.
    for (int i = 0; i < 4; i++) begin
      w_mem[i] = 32'hA0 + 32'(i);
      exp_w.push_back('{data: 32'hA0 + 32'(i), last: (i == 3)});
    end
    w_n = 4;
    exp_aw.push_back('{addr: 32'h4, len: 8'd3});
    exp_d.push_back('{resp: 2'b00, tmo: 1'b0, perr: 1'b0, lat: 7});
    issue(1'b1, 32'h4, 8'd3);
    wait_done(1);
    clear_src();

    // Read len=7, data 0x10..0x17, rlast on beat 8, toggling rd_data_ready.
    for (int i = 0; i < 8; i++) begin
      r_mem[i] = 32'h10 + 32'(i);
      r_rsp[i] = 2'b00;
      r_lst[i] = (i == 7);
      exp_r.push_back('{data: 32'h10 + 32'(i), last: (i == 7)});
    end
    r_n = 8;
    rd_tog_en = 1'b1;
    exp_ar.push_back('{addr: 32'h0, len: 8'd7});
    exp_d.push_back('{resp: 2'b00, tmo: 1'b0, perr: 1'b0, lat: -1});
    issue(1'b0, 32'h0, 8'd7);
    wait_done(2);
    rd_tog_en = 1'b0;
    clear_src();

    // Read len=3, SLVERR on beat 2, early rlast on beat 3, missing on beat 4.
    for (int i = 0; i < 4; i++) begin
      r_mem[i] = 32'h30 + 32'(i);
      r_rsp[i] = (i == 1) ? 2'b10 : 2'b00;
      r_lst[i] = (i == 2);
      exp_r.push_back('{data: 32'h30 + 32'(i), last: (i == 2)});
    end
    r_n = 4;
    exp_ar.push_back('{addr: 32'h40, len: 8'd3});
    exp_d.push_back('{resp: 2'b10, tmo: 1'b0, perr: 1'b1, lat: 6});
    issue(1'b0, 32'h40, 8'd3);
    wait_done(3);
    clear_src();

    // Minimum read: done 3 cycles after cmd.
    r_mem[0] = 32'h55;
    r_rsp[0] = 2'b00;
    r_lst[0] = 1'b1;
    r_n = 1;
    exp_r.push_back('{data: 32'h55, last: 1'b1});
    exp_ar.push_back('{addr: 32'h80, len: 8'd0});
    exp_d.push_back('{resp: 2'b00, tmo: 1'b0, perr: 1'b0, lat: 3});
    issue(1'b0, 32'h80, 8'd0);
    wait_done(4);
    clear_src();

    // Minimum write: done 4 cycles after cmd.
    w_mem[0] = 32'h77;
    w_n = 1;
    exp_w.push_back('{data: 32'h77, last: 1'b1});
    exp_aw.push_back('{addr: 32'hC0, len: 8'd0});
    exp_d.push_back('{resp: 2'b00, tmo: 1'b0, perr: 1'b0, lat: 4});
    issue(1'b1, 32'hC0, 8'd0);
    wait_done(5);
    clear_src();

    // Timeout: awready held low, abort 16 cycles after AW entry.
    aw_rdy_en = 1'b0;
    w_mem[0] = 32'h99;
    w_n = 1;
    exp_d.push_back('{resp: 2'b10, tmo: 1'b1, perr: 1'b0, lat: 17});
    issue(1'b1, 32'h100, 8'd0);
    wait_done(6);
    // Status holds after the pulse; fields still show the last command.
    tick(1);
    check_outs("status_hold", 16'h8015);
    aw_rdy_en = 1'b1;
    clear_src();

    // Reset in the middle of a 4-beat read, stalled before beat 2.
    for (int i = 0; i < 4; i++) begin
      r_mem[i] = 32'hE0 + 32'(i);
      r_rsp[i] = 2'b00;
      r_lst[i] = (i == 3);
    end
    r_n = 4;
    r_stall_at = 1;
    exp_r.push_back('{data: 32'hE0, last: 1'b0});
    exp_ar.push_back('{addr: 32'h180, len: 8'd3});
    issue(1'b0, 32'h180, 8'd3);
    for (int t = 0; t < 20 && rd_cnt < 10; t++) tick(1);
    tick(2);
    areset_n = 1'b0;
    check_outs("mid_burst_reset", 16'h0000);
    clear_src();
    tick(1);
    areset_n = 1'b1;
    check_outs("release_after_abort", 16'h8000);
    tick(3);

    // Normal command after the aborted read.
    w_mem[0] = 32'h5A5A;
    w_n = 1;
    exp_w.push_back('{data: 32'h5A5A, last: 1'b1});
    exp_aw.push_back('{addr: 32'h200, len: 8'd0});
    exp_d.push_back('{resp: 2'b00, tmo: 1'b0, perr: 1'b0, lat: 4});
    issue(1'b1, 32'h200, 8'd0);
    wait_done(7);
    clear_src();

    fin_req = 1'b1;
    for (int t = 0; t < 10 && !fin_ack; t++) tick(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axi_master_ctrl.md
# axi_master_ctrl

Single-outstanding AXI4 master that turns one command from a simple local interface into a complete AXI write (AW/W/B) or read (AR/R) burst. It is the initiator counterpart to the slave models in the AXI design: it drives address and data channels, counts beats, checks RLAST framing, reports the burst response, and abandons a stalled transaction after a programmable timeout. It sits between test or system logic and the AXI_if master side.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 256, cycles without any handshake before abort (≥2)
- aclk  in  1  clock, rising edge
- areset_n  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  start address; cmd_len in 8 (beats-1); cmd_size in 3; cmd_burst in 2
- wr_data_valid / wr_data_ready  in / out  1  local write-data handshake; wr_data in DATA_W
- rd_data_valid / rd_data_ready  out / in  1  local read-data handshake; rd_data out DATA_W; rd_last out 1
- done  out  1  one-cycle completion pulse; done_resp out 2; done_timeout out 1; done_proto_err out 1
- awaddr, awlen, awsize, awburst, awvalid  out; awready in
- wdata, wlast, wvalid  out; wready in
- bresp, bvalid  in; bready out
- araddr, arlen, arsize, arburst, arvalid  out; arready in
- rdata, rresp, rlast, rvalid  in; rready out

## Operation
- States: IDLE, AW, W, B, AR, R. One transaction in flight.
- IDLE: cmd_ready=1. On cmd_valid: latch addr/len/size/burst, clear beat_cnt, resp_acc, proto_err, timer; go to AW if cmd_write, else AR.
- AW: awvalid=1, aw* = latched fields, stable until awready → W.
- W: wvalid=wr_data_valid, wdata=wr_data, wr_data_ready=wready, wlast=(beat_cnt==len). On wvalid&&wready: beat_cnt+1; if wlast → B.
- B: bready=1. On bvalid → IDLE, done=1, done_resp=bresp.
- AR: arvalid=1, ar* = latched fields, stable until arready → R.
- R: rready=rd_data_ready, rd_data_valid=rvalid, rd_data=rdata, rd_last=rlast. On rvalid&&rready: beat_cnt+1; resp_acc=max(resp_acc,rresp); proto_err set if rlast≠(beat_cnt==len). Beat with beat_cnt==len → IDLE, done=1, done_resp=max(resp_acc,rresp), done_proto_err=accumulated flag incl. this beat.
- Early rlast (beat_cnt<len) flags proto_err but does not end the burst; burst ends on beat count only.
- Timeout: timer counts every non-IDLE cycle, clears on any AW/W/B/AR/R handshake. At TIMEOUT-1 without a handshake: go to IDLE, done=1, done_timeout=1, done_resp=2'b10; all valids/readies drop next cycle.
- beat_cnt 8-bit; len=255 gives 256 beats, no wrap before final beat. Address is not incremented by this block.
- done_* hold their values until the next done; done itself is a pulse.

## Timing
- Reset (async assert, sync release): state IDLE; cmd_ready=1 after release; all AXI valids/readies, wlast, wr_data_ready, rd_data_valid, rd_last, done, done_timeout, done_proto_err = 0; done_resp=0; aw*/ar* fields 0. Reset mid-burst abandons it immediately with no done.
- Channel valids/readies are decoded from the registered state; W and R data paths are combinational pass-throughs.
- Command accepted at edge N → awvalid/arvalid high in cycle N+1.
- Minimum write (len=0, all ready): cmd N, AW N+1, W N+2, B N+3, done in N+4, cmd_ready N+4.
- Minimum read (len=0): cmd N, AR N+1, R N+2, done in N+3.
- done is asserted in the first IDLE cycle after completion; a new command may be accepted in that same cycle.

## Test plan
- Write addr=0x4, len=3, burst=INCR, data 0xA0..0xA3, slave always ready, bresp=OKAY → 4 W beats, wlast only on 0xA3, done with done_resp=0, done in 7th cycle after cmd.
- Read addr=0x0, len=7, slave returns 0x10..0x17, rlast on beat 8, rd_data_ready toggling 1/0 → 8 beats delivered in order, done_resp=0, done_proto_err=0.
- Read len=3, slave rresp=SLVERR on beat 2, rlast on beat 3 → done_resp=2'b10, done_proto_err=1, burst still ends after beat 4.
- Write len=0, awready held low, TIMEOUT=16 → abort 16 cycles after AW entry, done_timeout=1, done_resp=2'b10, awvalid low next cycle.
- areset_n pulled low mid-read (beat 2 of 4) → all outputs 0 asynchronously, no done; after release next command completes normally.
